adder_share_sched: RTL and testbench

ADDER_SHARE_SCHED -- requirements
Module: adder_share_sched

---
 rtl/adder_share_sched_pkg.sv | 25 ++
 rtl/adder_share_sched_prefix_add8_cin.sv | 41 ++++
 rtl/adder_share_sched.sv | 161 ++++++++++++++++
 tb/tb_adder_share_sched.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_share_sched_pkg.sv
// Shared constants and types for the byte-serial shared adder scheduler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the default requester count, operand width, byte width, the
// per-operation byte count and the scheduler state encoding.
package adder_share_pkg;

    localparam int NUM_REQ_DEF   = 4;
    localparam int WORD_W_DEF    = 32;
    localparam int BYTE_W        = 8;
    localparam int NUM_BYTES_DEF = WORD_W_DEF / BYTE_W;

    // Number of byte-wide adder passes needed for a given operand width.
    function automatic int num_bytes(input int word_w);
        return word_w / BYTE_W;
    endfunction

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/adder_share_sched_prefix_add8_cin.sv
// 8-bit Kogge-Stone prefix adder with carry-in and carry-out.
// Latency: purely combinational.
// Backpressure: none (no handshake).
//
// Ports: a, b (8-bit operands), cin (carry-in), sum (8-bit result),
//        cout (carry out of bit 7).
module prefix_add8_cin
    import adder_share_pkg::*;
(
    input  logic [BYTE_W-1:0] a,
    input  logic [BYTE_W-1:0] b,
    input  logic              cin,
    output logic [BYTE_W-1:0] sum,
    output logic              cout
);

    logic [BYTE_W-1:0] g0, p0;
    logic [BYTE_W-1:0] g1, p1;
    logic [BYTE_W-1:0] g2, p2;
    logic [BYTE_W-1:0] g3, p3;
    logic [BYTE_W:0]   c;

    assign g0 = a & b;
    assign p0 = a ^ b;

    // Black-cell levels at span 1, 2, 4. Bits below the span pass through
    // unchanged: shifted-in zeros kill the generate term, shifted-in ones
    // keep the propagate term.
    assign g1 = g0 | (p0 & {g0[BYTE_W-2:0], 1'b0});
    assign p1 = p0 & {p0[BYTE_W-2:0], 1'b1};
    assign g2 = g1 | (p1 & {g1[BYTE_W-3:0], 2'b00});
    assign p2 = p1 & {p1[BYTE_W-3:0], 2'b11};
    assign g3 = g2 | (p2 & {g2[BYTE_W-5:0], 4'h0});
    assign p3 = p2 & {p2[BYTE_W-5:0], 4'hF};

    // g3/p3 now hold group generate/propagate over [i:0]; fold in cin.
    assign c    = {g3 | (p3 & {BYTE_W{cin}}), cin};
    assign sum  = p0 ^ c[BYTE_W-1:0];
    assign cout = c[BYTE_W];

endmodule

// File: rtl/adder_share_sched.sv
// Round-robin scheduler sharing one 8-bit adder among NUM_REQ requesters.
// Latency: accept in cycle N -> rsp_valid from cycle N+1+WORD_W/8.
// Backpressure: holds the response until rsp_ready; no grants until it drains.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_valid/req_ready  per-requester handshake (ready one-hot, IDLE only)
//   req_a/req_b/req_cin  packed operands, requester i at [i*WORD_W +: WORD_W]
//   rsp_valid/rsp_ready  result handshake
//   rsp_id/rsp_sum/rsp_cout  owner, A+B+cin mod 2^WORD_W, carry out
//   rsp_ovf              two's-complement overflow, only when the macro
//                        ADDER_SHARE_SCHED_OVF_EN is defined
module adder_share_sched
    import adder_share_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int WORD_W  = WORD_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*WORD_W-1:0] req_a,
    input  logic [NUM_REQ*WORD_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]        req_cin,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [1:0]                rsp_id,
    output logic [WORD_W-1:0]         rsp_sum,
    output logic                      rsp_cout
`ifdef ADDER_SHARE_SCHED_OVF_EN
    ,
    output logic                      rsp_ovf
`endif
);

    localparam int NB   = num_bytes(WORD_W);
    localparam int IDXW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NB - 1);

    state_t              state;
    logic [1:0]          rr_ptr;
    logic [IDXW-1:0]     byte_idx;
    logic                carry;
    logic [WORD_W-1:0]   a_q;
    logic [WORD_W-1:0]   b_q;
    logic [WORD_W-1:0]   acc;
    logic [1:0]          id_q;

    logic [NUM_REQ-1:0]  grant;
    logic [1:0]          gidx;
    logic                accept;
    logic [BYTE_W-1:0]   sum8;
    logic                cout8;
    logic [WORD_W-1:0]   next_acc;

    // Round-robin search starting at rr_ptr; first asserted valid wins.
    always_comb begin
        int  idx;
        logic found;
        grant = '0;
        gidx  = '0;
        idx   = 0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!found && req_valid[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                gidx       = 2'(idx);
            end
        end
    end

    // Grants are offered only in IDLE and never while reset is asserted.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign accept    = |req_ready;

    // Operands are shifted right one byte per BUSY cycle, so the adder
    // always consumes the low byte.
    prefix_add8_cin u_add (
        .a    (a_q[BYTE_W-1:0]),
        .b    (b_q[BYTE_W-1:0]),
        .cin  (carry),
        .sum  (sum8),
        .cout (cout8)
    );

    // Result bytes enter at the top and shift down; after NB passes the
    // first (LSB) byte has reached bit 0.
    assign next_acc = (acc >> BYTE_W) | (WORD_W'(sum8) << (WORD_W - BYTE_W));

`ifdef ADDER_SHARE_SCHED_OVF_EN
    logic carry_into_msb;
    // On the last pass the adder sees the operand MSB byte; the carry into
    // bit 7 is recovered from the sum bit.
    assign carry_into_msb = a_q[BYTE_W-1] ^ b_q[BYTE_W-1] ^ sum8[BYTE_W-1];
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            byte_idx  <= '0;
            carry     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            id_q      <= '0;
            rsp_sum   <= '0;
            rsp_cout  <= 1'b0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
`ifdef ADDER_SHARE_SCHED_OVF_EN
            rsp_ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a_q      <= req_a[gidx*WORD_W +: WORD_W];
                        b_q      <= req_b[gidx*WORD_W +: WORD_W];
                        carry    <= req_cin[gidx];
                        id_q     <= gidx;
                        byte_idx <= '0;
                        rr_ptr   <= (gidx == 2'(NUM_REQ - 1)) ? 2'd0 : gidx + 2'd1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    a_q      <= a_q >> BYTE_W;
                    b_q      <= b_q >> BYTE_W;
                    carry    <= cout8;
                    acc      <= next_acc;
                    byte_idx <= byte_idx + 1'b1;
                    if (byte_idx == LAST_IDX) begin
                        byte_idx  <= '0;
                        rsp_sum   <= next_acc;
                        rsp_cout  <= cout8;
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
`ifdef ADDER_SHARE_SCHED_OVF_EN
                        rsp_ovf   <= carry_into_msb ^ cout8;
`endif
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_sched.sv
// Self-checking bench for adder_share_sched: directed cases plus random
// traffic compared every cycle against a transaction-level model.
module tb_adder_share_sched;

    localparam int NR = 4;
    localparam int W  = 32;
    localparam int NB = W / 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*W-1:0]   req_a;
    logic [NR*W-1:0]   req_b;
    logic [NR-1:0]     req_cin;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;
`ifdef ADDER_SHARE_SCHED_OVF_EN
    logic              rsp_ovf;
`endif

    always #5 clk = ~clk;

    adder_share_sched #(.NUM_REQ(NR), .WORD_W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout)
`ifdef ADDER_SHARE_SCHED_OVF_EN
        ,
        .rsp_ovf   (rsp_ovf)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    typedef struct {
        logic [1:0]  id;
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    function automatic res_t compute(input int id, input logic [31:0] a,
                                     input logic [31:0] b, input logic cin);
        res_t r;
        logic [32:0] t;
        t      = {1'b0, a} + {1'b0, b} + {32'd0, cin};
        r.id   = 2'(id);
        r.sum  = t[31:0];
        r.cout = t[32];
        r.ovf  = (a[31] == b[31]) && (t[31] != a[31]);
        return r;
    endfunction

    function automatic logic [3:0] rr_exp(input logic [3:0] v, input int ptr);
        for (int k = 0; k < NR; k++) begin
            if (v[(ptr + k) % NR]) return 4'(1 << ((ptr + k) % NR));
        end
        return 4'b0000;
    endfunction

    logic mdl_on   = 1'b0;
    logic mdl_busy = 1'b0;
    int   mdl_ptr  = 0;
    int   free_at  = 0;
    int   rsp_at   = 0;
    res_t cur;
    res_t last;
    int   resp_cnt [NR];
    int   dut_cnt  [NR];

    initial begin
        for (int i = 0; i < NR; i++) begin
            resp_cnt[i] = 0;
            dut_cnt[i]  = 0;
        end
        last = '{2'd0, 32'd0, 1'b0, 1'b0};
        cur  = last;
    end

    always @(negedge clk) begin
        logic [3:0] exp_rdy;
        logic       exp_rv;
        int         gi;
        exp_rdy = 4'b0000;
        exp_rv  = 1'b0;
        gi      = 0;
        if (rst_n === 1'b1 && rsp_valid && rsp_ready) dut_cnt[rsp_id]++;
        if (mdl_on) begin
            if (rst_n && !mdl_busy && cyc >= free_at) exp_rdy = rr_exp(req_valid, mdl_ptr);
            chk("req_ready", 64'(req_ready), 64'(exp_rdy));
            exp_rv = mdl_busy && (cyc >= rsp_at);
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
            if (exp_rv) begin
                chk("rsp_sum", 64'(rsp_sum), 64'(cur.sum));
                chk("rsp_cout", 64'(rsp_cout), 64'(cur.cout));
                chk("rsp_id", 64'(rsp_id), 64'(cur.id));
`ifdef ADDER_SHARE_SCHED_OVF_EN
                chk("rsp_ovf", 64'(rsp_ovf), 64'(cur.ovf));
`endif
            end else begin
                chk("hold_sum", 64'(rsp_sum), 64'(last.sum));
                chk("hold_cout", 64'(rsp_cout), 64'(last.cout));
                chk("hold_id", 64'(rsp_id), 64'(last.id));
`ifdef ADDER_SHARE_SCHED_OVF_EN
                chk("hold_ovf", 64'(rsp_ovf), 64'(last.ovf));
`endif
            end
        end
        if (!rst_n) begin
            mdl_on   = 1'b1;
            mdl_busy = 1'b0;
            mdl_ptr  = 0;
            free_at  = cyc + 1;
            last     = '{2'd0, 32'd0, 1'b0, 1'b0};
        end else if (mdl_on) begin
            if (exp_rv && rsp_ready) begin
                mdl_busy = 1'b0;
                free_at  = cyc + 1;
                last     = cur;
                resp_cnt[cur.id]++;
            end
            if (exp_rdy != 4'b0000) begin
                for (int i = 0; i < NR; i++) if (exp_rdy[i]) gi = i;
                mdl_busy = 1'b1;
                rsp_at   = cyc + 1 + NB;
                mdl_ptr  = (gi + 1) % NR;
                cur      = compute(gi, req_a[gi*W +: W], req_b[gi*W +: W], req_cin[gi]);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic cap_ovf = 1'b0;

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, output logic [31:0] s, output logic co,
                          output logic [1:0] rid, output int lat, output logic [3:0] gnt,
                          output int wait_cyc);
        logic got;
        int   t0;
        got = 1'b0; t0 = 0; lat = 0; gnt = '0; wait_cyc = 0;
        s = '0; co = 1'b0; rid = '0;
        req_valid         = 4'(1 << id);
        req_a[id*W +: W]  = a;
        req_b[id*W +: W]  = b;
        req_cin[id]       = cin;
        rsp_ready         = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin got = 1'b1; break; end
            wait_cyc++;
            tick();
        end
        chk("grant_seen", 64'(got), 64'd1);
        gnt = req_ready;
        t0  = cyc;
        tick();
        // Scramble request inputs; the in-flight result must not change.
        req_valid = '0;
        req_a     = {$urandom, $urandom, $urandom, $urandom};
        req_b     = {$urandom, $urandom, $urandom, $urandom};
        req_cin   = 4'($urandom);
        got       = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; break; end
            tick();
        end
        chk("rsp_seen", 64'(got), 64'd1);
        lat = cyc - t0;
        s   = rsp_sum;
        co  = rsp_cout;
        rid = rsp_id;
`ifdef ADDER_SHARE_SCHED_OVF_EN
        cap_ovf = rsp_ovf;
`endif
        tick();
    endtask

    task automatic drain();
        logic got;
        got       = 1'b0;
        rsp_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) begin got = 1'b1; tick(); break; end
            tick();
        end
        chk("drain_rsp", 64'(got), 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [31:0] s, s0;
        logic        co;
        logic [1:0]  rid;
        logic [3:0]  gnt;
        int          lat, wc, ng, total;
        int          ord [5];
        int          exp_ord [5] = '{0, 1, 2, 3, 0};

        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; rsp_ready = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        chk("reset_ready", 64'(req_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_sum", 64'(rsp_sum), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Single request, LSB byte carries into byte 1.
        run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, s, co, rid, lat, gnt, wc);
        chk("t033_same_cycle", 64'(wc), 64'd0);
        chk("t033_grant", 64'(gnt), 64'h1);
        chk("t033_latency", 64'(lat), 64'd5);
        chk("t033_sum", 64'(s), 64'h0000_0100);
        chk("t033_cout", 64'(co), 64'd0);
        chk("t033_id", 64'(rid), 64'd0);

        // Carry ripples through all four bytes.
        run_op(0, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, s, co, rid, lat, gnt, wc);
        chk("t034a_sum", 64'(s), 64'h0);
        chk("t034a_cout", 64'(co), 64'd1);
`ifdef ADDER_SHARE_SCHED_OVF_EN
        chk("t034a_ovf", 64'(cap_ovf), 64'd0);
`endif
        run_op(0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, s, co, rid, lat, gnt, wc);
        chk("t034b_sum", 64'(s), 64'h8000_0000);
        chk("t034b_cout", 64'(co), 64'd0);
`ifdef ADDER_SHARE_SCHED_OVF_EN
        chk("t034b_ovf", 64'(cap_ovf), 64'd1);
`endif

        // All requesters valid from reset: strict rotation.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_a[i*W +: W] = 32'h1111_1111 * (i + 1);
            req_b[i*W +: W] = 32'hF0F0_F0F0 + i;
            req_cin[i]      = i[0];
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        ng = 0;
        for (int k = 0; k < 60 && ng < 5; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) begin
                for (int i = 0; i < NR; i++) if (req_ready[i]) ord[ng] = i;
                ng++;
            end
            tick();
        end
        chk("t035_grants", 64'(ng), 64'd5);
        for (int k = 0; k < 5; k++) chk("t035_order", 64'(ord[k]), 64'(exp_ord[k]));
        req_valid = '0;
        drain();

        // Back-pressure: response held with other requesters pushing.
        req_valid = 4'b0001;
        req_a[W-1:0] = 32'hDEAD_BEEF;
        req_b[W-1:0] = 32'h1234_5678;
        rsp_ready = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != 4'b0000) break;
            tick();
        end
        tick();
        req_valid = 4'b1111;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rsp_valid) break;
            tick();
        end
        s0 = rsp_sum;
        chk("t036_sum", 64'(s0), 64'(32'hDEAD_BEEF + 32'h1234_5678));
        tick();
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t036_valid_held", 64'(rsp_valid), 64'd1);
            chk("t036_sum_stable", 64'(rsp_sum), 64'(s0));
            chk("t036_no_grant", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        chk("t036_idle_after", 64'(rsp_valid), 64'd0);
        chk("t036_grant_after", 64'(req_ready != 4'b0000), 64'd1);
        tick();
        req_valid = '0;
        drain();

        // Reset in the second BUSY cycle discards the operation.
        do_reset();
        req_valid = 4'b0010;
        @(negedge clk);
        chk("t037_grant1", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("t037_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        req_valid = 4'b1111;
        @(negedge clk);
        chk("t037_grant0", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        drain();

        // Random traffic with random back-pressure.
        for (int c = 0; c < 9000; c++) begin
            req_valid = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            for (int i = 0; i < NR; i++) begin
                case ($urandom_range(0, 5))
                    0:       req_a[i*W +: W] = 32'hFFFF_FFFF;
                    1:       req_a[i*W +: W] = 32'h7FFF_FFFF;
                    default: req_a[i*W +: W] = $urandom;
                endcase
                req_b[i*W +: W] = ($urandom_range(0, 4) == 0) ? 32'h0000_0001 : $urandom;
            end
            req_cin   = 4'($urandom);
            rsp_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        repeat (20) tick();

        total = 0;
        for (int i = 0; i < NR; i++) begin
            chk("id_count", 64'(dut_cnt[i]), 64'(resp_cnt[i]));
            total += dut_cnt[i];
        end
        chk("random_ops_seen", 64'(total > 500), 64'd1);
        chk("model_drained", 64'(mdl_busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

endmodule
